// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces raw buttons and switch bus into clean levels and pulses
module input_conditioner #(
    parameter int NUM_BTN   = 4,
    parameter int SW_WIDTH  = 8,
    parameter int DB_CYCLES = 250000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_BTN-1:0]  Btn_n,
    input  logic [SW_WIDTH-1:0] Sw,
    output logic [NUM_BTN-1:0]  Btn_H,
    output logic [NUM_BTN-1:0]  Btn_Pulse,
    output logic [SW_WIDTH-1:0] Sw_S,
    output logic                Sw_Chg
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic [NUM_BTN-1:0]  btn_s1_q, btn_s2_q;
    logic [NUM_BTN-1:0]  pulse_q, pulse_d;
    state_t              state_q [NUM_BTN];
    state_t              state_d [NUM_BTN];
    logic [CW-1:0]       cnt_q [NUM_BTN];
    logic [CW-1:0]       cnt_d [NUM_BTN];
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q, sw_prev_q, sw_s_q, sw_s_d;
    logic [CW-1:0]       sw_cnt_q, sw_cnt_d;
    logic                sw_chg_q, sw_chg_d;
    logic                sw_settling, sw_done;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            btn_s1_q  <= '1;
            btn_s2_q  <= '1;
            pulse_q   <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_prev_q <= '0;
            sw_s_q    <= '0;
            sw_cnt_q  <= '0;
            sw_chg_q  <= 1'b0;
            for (int b = 0; b < NUM_BTN; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
            end
        end else begin
            btn_s1_q  <= Btn_n;
            btn_s2_q  <= btn_s1_q;
            pulse_q   <= pulse_d;
            sw_s1_q   <= Sw;
            sw_s2_q   <= sw_s1_q;
            sw_prev_q <= sw_s2_q;
            sw_s_q    <= sw_s_d;
            sw_cnt_q  <= sw_cnt_d;
            sw_chg_q  <= sw_chg_d;
            for (int b = 0; b < NUM_BTN; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BTN; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = '0;
            pulse_d[b] = 1'b0;
            Btn_H[b]   = state_q[b] == HELD || state_q[b] == RELEASE_WAIT;
            case (state_q[b])
                IDLE: state_d[b] = btn_s2_q[b] ? IDLE : PRESS_WAIT;
                PRESS_WAIT: begin
                    state_d[b] = btn_s2_q[b] ? IDLE : (cnt_q[b] == CNT_MAX) ? HELD : PRESS_WAIT;
                    cnt_d[b]   = (btn_s2_q[b] || cnt_q[b] == CNT_MAX) ? '0 : cnt_q[b] + 1'b1;
                    pulse_d[b] = !btn_s2_q[b] && cnt_q[b] == CNT_MAX;
                end
                HELD: state_d[b] = btn_s2_q[b] ? RELEASE_WAIT : HELD;
                RELEASE_WAIT: begin
                    state_d[b] = !btn_s2_q[b] ? HELD : (cnt_q[b] == CNT_MAX) ? IDLE : RELEASE_WAIT;
                    cnt_d[b]   = (!btn_s2_q[b] || cnt_q[b] == CNT_MAX) ? '0 : cnt_q[b] + 1'b1;
                end
                default: state_d[b] = IDLE;
            endcase
        end
    end

    // the word only counts while it is unchanged since last cycle and differs from the accepted value
    always_comb begin
        sw_settling = sw_s2_q == sw_prev_q && sw_s2_q != sw_s_q;
        sw_done     = sw_settling && sw_cnt_q == CNT_MAX;
        sw_cnt_d    = (sw_settling && !sw_done) ? sw_cnt_q + 1'b1 : '0;
        sw_s_d      = sw_done ? sw_s2_q : sw_s_q;
        sw_chg_d    = sw_done;
    end

    assign Btn_Pulse = pulse_q;
    assign Sw_S      = sw_s_q;
    assign Sw_Chg    = sw_chg_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table-driven directed checks of the input conditioner with DB_CYCLES=4
module tb_input_conditioner;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] Btn_n = 4'hF;
    logic [7:0] Sw = 8'hA5;
    logic [3:0] Btn_H, Btn_Pulse;
    logic [7:0] Sw_S;
    logic       Sw_Chg;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] btn_n;
        logic [7:0] sw;
        logic [3:0] h;
        logic [3:0] p;
        logic [7:0] sws;
        logic       chg;
    } vec_t;
    vec_t tbl[$];

    input_conditioner #(.NUM_BTN(4), .SW_WIDTH(8), .DB_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .Btn_n(Btn_n), .Sw(Sw),
        .Btn_H(Btn_H), .Btn_Pulse(Btn_Pulse), .Sw_S(Sw_S), .Sw_Chg(Sw_Chg)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int n, input logic [3:0] b, input logic [7:0] s,
                       input logic [3:0] h, input logic [3:0] p, input logic [7:0] ss, input logic c);
        vec_t v;
        v.btn_n = b; v.sw = s; v.h = h; v.p = p; v.sws = ss; v.chg = c;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        int chg_cnt;
        // single press on button 1, release
        add(6,  4'hD, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        add(1,  4'hD, 8'hA5, 4'h2, 4'h2, 8'hA5, 0);
        add(13, 4'hD, 8'hA5, 4'h2, 4'h0, 8'hA5, 0);
        add(6,  4'hF, 8'hA5, 4'h2, 4'h0, 8'hA5, 0);
        add(4,  4'hF, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        // short bounces on button 0 never qualify
        add(3,  4'hE, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        add(1,  4'hF, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        add(3,  4'hE, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        add(8,  4'hF, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        // accepted press, release glitch, then real release
        add(6,  4'hE, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        add(1,  4'hE, 8'hA5, 4'h1, 4'h1, 8'hA5, 0);
        add(1,  4'hE, 8'hA5, 4'h1, 4'h0, 8'hA5, 0);
        add(2,  4'hF, 8'hA5, 4'h1, 4'h0, 8'hA5, 0);
        add(6,  4'hE, 8'hA5, 4'h1, 4'h0, 8'hA5, 0);
        add(6,  4'hF, 8'hA5, 4'h1, 4'h0, 8'hA5, 0);
        add(4,  4'hF, 8'hA5, 4'h0, 4'h0, 8'hA5, 0);
        // switch to 00, then FF glitch before 3C
        add(6,  4'hF, 8'h00, 4'h0, 4'h0, 8'hA5, 0);
        add(1,  4'hF, 8'h00, 4'h0, 4'h0, 8'h00, 1);
        add(1,  4'hF, 8'h00, 4'h0, 4'h0, 8'h00, 0);
        add(2,  4'hF, 8'hFF, 4'h0, 4'h0, 8'h00, 0);
        add(6,  4'hF, 8'h3C, 4'h0, 4'h0, 8'h00, 0);
        add(1,  4'hF, 8'h3C, 4'h0, 4'h0, 8'h3C, 1);
        add(4,  4'hF, 8'h3C, 4'h0, 4'h0, 8'h3C, 0);
        // word returns to accepted value before qualifying
        add(3,  4'hF, 8'h81, 4'h0, 4'h0, 8'h3C, 0);
        add(8,  4'hF, 8'h3C, 4'h0, 4'h0, 8'h3C, 0);
        // all buttons at once
        add(6,  4'h0, 8'h3C, 4'h0, 4'h0, 8'h3C, 0);
        add(1,  4'h0, 8'h3C, 4'hF, 4'hF, 8'h3C, 0);
        add(1,  4'h0, 8'h3C, 4'hF, 4'h0, 8'h3C, 0);
        add(6,  4'hF, 8'h3C, 4'hF, 4'h0, 8'h3C, 0);
        add(2,  4'hF, 8'h3C, 4'h0, 4'h0, 8'h3C, 0);

        // reset with switch already at A5
        tick();
        tick();
        chk("rst_h", 0, Btn_H, 0);
        chk("rst_p", 0, Btn_Pulse, 0);
        chk("rst_sws", 0, Sw_S, 0);
        chk("rst_chg", 0, Sw_Chg, 0);
        Reset = 1'b1;
        chg_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chg_cnt += int'(Sw_Chg);
            chk("t1_sws", k, Sw_S, (k >= 7) ? 8'hA5 : 8'h00);
            chk("t1_chg", k, Sw_Chg, k == 7);
            chk("t1_h", k, Btn_H, 0);
        end
        chk("t1_chg_count", 0, chg_cnt, 1);

        foreach (tbl[i]) begin
            Btn_n = tbl[i].btn_n;
            Sw = tbl[i].sw;
            tick();
            chk("tbl_h", i, Btn_H, tbl[i].h);
            chk("tbl_p", i, Btn_Pulse, tbl[i].p);
            chk("tbl_sws", i, Sw_S, tbl[i].sws);
            chk("tbl_chg", i, Sw_Chg, tbl[i].chg);
        end

        // reset while button 2 is held
        Btn_n = 4'hB;
        for (int k = 0; k < 8; k++) tick();
        chk("t6_held", 0, Btn_H, 4'h4);
        #3 Reset = 1'b0;
        #1;
        chk("t6_async_h", 0, Btn_H, 0);
        chk("t6_async_sws", 0, Sw_S, 0);
        chk("t6_async_p", 0, Btn_Pulse, 0);
        tick();
        tick();
        chk("t6_inrst_h", 0, Btn_H, 0);
        Reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t6_h", k, Btn_H, (k >= 7) ? 4'h4 : 4'h0);
            chk("t6_p", k, Btn_Pulse, (k == 7) ? 4'h4 : 4'h0);
            chk("t6_sws", k, Sw_S, (k >= 7) ? 8'h3C : 8'h00);
            chk("t6_chg", k, Sw_Chg, k == 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
